// File: rtl/alu_8bit.sv
// alu_8bit: 4-bit operand ALU with a single registered 8-bit result stage.
// Operands are zero-extended to 8 bits, and the opcode selects the operation.
// The result and its status flags are captured one cycle after the input is accepted.
module alu_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] opcode,
  output logic [7:0] result,
  output logic       out_valid,
  output logic       zero,
  output logic       neg
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NOT  = 3'b101,
    OP_XOR  = 3'b110,
    OP_XNOR = 3'b111
  } alu_op_e;

  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [3:0] logic_nib;
  logic [7:0] result_d;
  logic       neg_d;
  logic       zero_d;

  logic [7:0] result_q;
  logic       out_valid_q;
  logic       zero_q;
  logic       neg_q;

  assign a_ext = {4'h0, a};
  assign b_ext = {4'h0, b};

  // Next result: one combinational case on the opcode.
  // Logic ops only ever produce the low nibble.
  always_comb begin
    logic_nib = 4'h0;
    result_d  = 8'h00;
    neg_d     = 1'b0;
    case (alu_op_e'(opcode))
      OP_ADD:  result_d = a_ext + b_ext;
      OP_SUB: begin
        result_d = a_ext - b_ext;
        neg_d    = (a < b);
      end
      OP_MUL:  result_d = a_ext * b_ext;
      OP_AND: begin
        logic_nib = a & b;
        result_d  = {4'h0, logic_nib};
      end
      OP_OR: begin
        logic_nib = a | b;
        result_d  = {4'h0, logic_nib};
      end
      OP_NOT: begin
        logic_nib = ~a;
        result_d  = {4'h0, logic_nib};
      end
      OP_XOR: begin
        logic_nib = a ^ b;
        result_d  = {4'h0, logic_nib};
      end
      OP_XNOR: begin
        logic_nib = ~(a ^ b);
        result_d  = {4'h0, logic_nib};
      end
      default: result_d = 8'h00;
    endcase
    zero_d = (result_d == 8'h00);
  end

  // Output register stage.
  // Reset wins over a same-cycle accept. An idle cycle holds the result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= 8'h00;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        zero_q   <= zero_d;
        neg_q    <= neg_d;
      end
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed testbench for alu_8bit.
// Each step drives one set of inputs, waits for the next clock edge, and checks the registered outputs.
module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] opcode;
  logic [7:0] result;
  logic       out_valid;
  logic       zero;
  logic       neg;

  int checks;
  int failures;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] MUL  = 3'b010;
  localparam logic [2:0] AND_ = 3'b011;
  localparam logic [2:0] OR_  = 3'b100;
  localparam logic [2:0] NOT_ = 3'b101;
  localparam logic [2:0] XOR_ = 3'b110;
  localparam logic [2:0] XNOR = 3'b111;

  alu_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic step(input logic r, input logic v, input logic [3:0] av,
                      input logic [3:0] bv, input logic [2:0] op);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    opcode   = op;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] res_exp, input logic ov_exp,
                     input logic z_exp, input logic n_exp);
    checks++;
    assert (result === res_exp) else begin
      failures++;
      $error("FAIL %s result observed=%h expected=%h", tag, result, res_exp);
    end
    checks++;
    assert (out_valid === ov_exp) else begin
      failures++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, ov_exp);
    end
    checks++;
    assert (zero === z_exp) else begin
      failures++;
      $error("FAIL %s zero observed=%b expected=%b", tag, zero, z_exp);
    end
    checks++;
    assert (neg === n_exp) else begin
      failures++;
      $error("FAIL %s neg observed=%b expected=%b", tag, neg, n_exp);
    end
    $display("step %-12s a=%h b=%h op=%b -> result=%h ov=%b z=%b n=%b",
             tag, a, b, opcode, result, out_valid, zero, neg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; in_valid = 1'b0; a = 4'h0; b = 4'h0; opcode = ADD;

    // Reset has priority over an input presented in the same cycle
    step(1, 1, 4'd1, 4'd2, ADD);   chk("rst0", 8'h00, 0, 0, 0);
    step(1, 1, 4'd1, 4'd2, ADD);   chk("rst1", 8'h00, 0, 0, 0);
    step(0, 0, 4'd1, 4'd2, ADD);   chk("idle0", 8'h00, 0, 0, 0);
    step(0, 0, 4'd1, 4'd2, ADD);   chk("idle1", 8'h00, 0, 0, 0);

    // Back-to-back ADD/MUL
    step(0, 1, 4'd1, 4'd2, ADD);   chk("add1+2", 8'h03, 1, 0, 0);
    step(0, 1, 4'd6, 4'd6, ADD);   chk("add6+6", 8'h0C, 1, 0, 0);
    step(0, 1, 4'd12, 4'd7, MUL);  chk("mul12x7", 8'h54, 1, 0, 0);
    step(0, 1, 4'd15, 4'd3, MUL);  chk("mul15x3", 8'h2D, 1, 0, 0);
    step(0, 1, 4'd15, 4'd15, MUL); chk("mul15x15", 8'hE1, 1, 0, 0);

    // SUB, including a negative result held across an idle cycle
    step(0, 1, 4'd12, 4'd3, SUB);  chk("sub12-3", 8'h09, 1, 0, 0);
    step(0, 1, 4'd13, 4'd10, SUB); chk("sub13-10", 8'h03, 1, 0, 0);
    step(0, 1, 4'd3, 4'd12, SUB);  chk("sub3-12", 8'hF7, 1, 0, 1);
    step(0, 0, 4'd0, 4'd0, ADD);   chk("subhold", 8'hF7, 0, 0, 1);
    step(0, 1, 4'd5, 4'd5, SUB);   chk("sub5-5", 8'h00, 1, 1, 0);

    // Logic ops
    step(0, 1, 4'b1100, 4'b0111, AND_); chk("and", 8'h04, 1, 0, 0);
    step(0, 1, 4'b0101, 4'b1011, OR_);  chk("or", 8'h0F, 1, 0, 0);
    step(0, 1, 4'b1001, 4'b1111, NOT_); chk("not", 8'h06, 1, 0, 0);
    step(0, 1, 4'b0111, 4'b1011, XOR_); chk("xor", 8'h0C, 1, 0, 0);
    step(0, 1, 4'b0110, 4'b0110, XNOR); chk("xnor_eq", 8'h0F, 1, 0, 0);
    step(0, 1, 4'b0011, 4'b1110, XNOR); chk("xnor_ne", 8'h02, 1, 0, 0);

    // Hold and valid gating
    step(0, 1, 4'd6, 4'd6, ADD);   chk("add_hold", 8'h0C, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'd15, 4'd15, MUL); chk("gate_idle", 8'h0C, 0, 0, 0);
    end

    // Reset mid-stream, starting from a zero=1 state
    step(0, 1, 4'd5, 4'd5, SUB);   chk("pre_rst", 8'h00, 1, 1, 0);
    step(0, 1, 4'd15, 4'd15, MUL); chk("mul_pre", 8'hE1, 1, 0, 0);
    step(0, 1, 4'd5, 4'd5, SUB);   chk("pre_rst2", 8'h00, 1, 1, 0);
    step(1, 1, 4'd15, 4'd15, MUL); chk("rst_mid", 8'h00, 0, 0, 0);
    step(0, 0, 4'd15, 4'd15, MUL); chk("post_rst", 8'h00, 0, 0, 0);
    step(0, 1, 4'd1, 4'd2, ADD);   chk("after_rst", 8'h03, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
